// File: rtl/gf_sbox_pipe.sv
// Three-stage pipelined AES S-box (four byte lanes) on composite-field GF(((2^2)^2)^2) arithmetic.
// Define GF_SBOX_INV_EN to add the per-word `inv` input that selects InvSubBytes.
module gf_sbox_pipe #(
    parameter int LANES = 4,
    parameter int TAG_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic [TAG_W-1:0]     in_tag,
`ifdef GF_SBOX_INV_EN
    input  logic                 inv,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);

    // A GF(2^4) operand together with the pre-summed terms its multipliers consume.
    typedef struct packed {
        logic [3:0] n;
        logic [1:0] p;
        logic [1:0] b;
        logic       s;
    } gf4_op_t;

    typedef struct packed {
        gf4_op_t h;
        gf4_op_t l;
        gf4_op_t hl;
    } s1_lane_t;

    typedef struct packed {
        gf4_op_t dinv;
        gf4_op_t h;
        gf4_op_t hl;
    } s2_lane_t;

    localparam logic [3:0] LAMBDA = 4'hC;

    function automatic gf4_op_t prep(input logic [3:0] n);
        gf4_op_t r;
        r.n = n;
        r.p = n[3:2] ^ n[1:0];
        r.b = {n[3] ^ n[2], n[1] ^ n[0]};
        r.s = n[3] ^ n[2] ^ n[1] ^ n[0];
        return r;
    endfunction

    // GF(2^2) multiply, x^2+x+1, taking each operand's bit-pair sum precomputed.
    function automatic logic [1:0] gf2_mul(input logic [1:0] a, input logic as,
                                           input logic [1:0] b, input logic bs);
        logic lo;
        lo = a[0] & b[0];
        return {(as & bs) ^ lo, (a[1] & b[1]) ^ lo};
    endfunction

    function automatic logic [3:0] gf4_mul(input gf4_op_t x, input gf4_op_t y);
        logic [1:0] hh, ll, pp;
        hh = gf2_mul(x.n[3:2], x.b[1], y.n[3:2], y.b[1]);
        ll = gf2_mul(x.n[1:0], x.b[0], y.n[1:0], y.b[0]);
        pp = gf2_mul(x.p, x.s, y.p, y.s);
        return {pp ^ ll, {hh[1] ^ hh[0], hh[1]} ^ ll};
    endfunction

    // Exhaustive search reduces to a 16-entry table; 0 finds no match and maps to 0.
    function automatic logic [3:0] gf4_inv(input logic [3:0] d);
        logic [3:0] r;
        r = 4'h0;
        for (int j = 1; j < 16; j++) begin
            if (gf4_mul(prep(d), prep(4'(j))) == 4'h1) r = 4'(j);
        end
        return r;
    endfunction

    function automatic logic [7:0] iso(input logic [7:0] q);
        return {q[7] ^ q[5],
                q[7] ^ q[6] ^ q[4] ^ q[3] ^ q[2] ^ q[1],
                q[7] ^ q[5] ^ q[3] ^ q[2],
                q[7] ^ q[5] ^ q[3] ^ q[2] ^ q[1],
                q[7] ^ q[6] ^ q[2] ^ q[1],
                q[7] ^ q[4] ^ q[3] ^ q[2] ^ q[1],
                q[6] ^ q[4] ^ q[1],
                q[6] ^ q[1] ^ q[0]};
    endfunction

    function automatic logic [7:0] iso_inv(input logic [7:0] q);
        return {q[7] ^ q[6] ^ q[5] ^ q[1],
                q[6] ^ q[2],
                q[6] ^ q[5] ^ q[1],
                q[6] ^ q[5] ^ q[4] ^ q[2] ^ q[1],
                q[5] ^ q[4] ^ q[3] ^ q[2] ^ q[1],
                q[7] ^ q[4] ^ q[3] ^ q[2] ^ q[1],
                q[5] ^ q[4],
                q[6] ^ q[5] ^ q[4] ^ q[2] ^ q[0]};
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

`ifdef GF_SBOX_INV_EN
    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        logic [7:0] x;
        x = b ^ 8'h63;
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]};
    endfunction
`endif

    function automatic s1_lane_t stage1(input logic [7:0] x);
        s1_lane_t r;
        logic [7:0] m;
        m    = iso(x);
        r.h  = prep(m[7:4]);
        r.l  = prep(m[3:0]);
        r.hl = prep(m[7:4] ^ m[3:0]);
        return r;
    endfunction

    function automatic s2_lane_t stage2(input s1_lane_t a);
        s2_lane_t r;
        logic [3:0] d;
        d      = gf4_mul(prep(gf4_mul(a.h, a.h)), prep(LAMBDA)) ^ gf4_mul(a.hl, a.l);
        r.dinv = prep(gf4_inv(d));
        r.h    = a.h;
        r.hl   = a.hl;
        return r;
    endfunction

    function automatic logic [7:0] stage3(input s2_lane_t a);
        return iso_inv({gf4_mul(a.h, a.dinv), gf4_mul(a.hl, a.dinv)});
    endfunction

    logic                      v1, v2, v3;
    logic                      adv1, adv2, adv3;
    s1_lane_t [LANES-1:0]      s1_q, s1_d;
    s2_lane_t [LANES-1:0]      s2_q, s2_d;
    logic [8*LANES-1:0]        s3_q, s3_d;
    logic [TAG_W-1:0]          t1, t2, t3;
`ifdef GF_SBOX_INV_EN
    logic                      inv1, inv2;
`endif

    // A stage may move whenever the stage after it is empty or moving, so bubbles collapse.
    assign adv3      = !v3 || out_ready;
    assign adv2      = !v2 || adv3;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = v3;
    assign out_data  = s3_q;
    assign out_tag   = t3;
    assign busy      = v1 | v2 | v3;

    always_comb begin
        s1_d = '0;
        s2_d = '0;
        s3_d = '0;
        for (int k = 0; k < LANES; k++) begin
`ifdef GF_SBOX_INV_EN
            s1_d[k] = stage1(inv ? inv_affine(in_data[8*k +: 8]) : in_data[8*k +: 8]);
            s3_d[8*k +: 8] = inv2 ? stage3(s2_q[k]) : affine(stage3(s2_q[k]));
`else
            s1_d[k] = stage1(in_data[8*k +: 8]);
            s3_d[8*k +: 8] = affine(stage3(s2_q[k]));
`endif
            s2_d[k] = stage2(s1_q[k]);
        end
    end

    // Payload only loads with a valid word, so a collapsed bubble leaves stale data untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
            t1   <= '0;
            t2   <= '0;
            t3   <= '0;
`ifdef GF_SBOX_INV_EN
            inv1 <= 1'b0;
            inv2 <= 1'b0;
`endif
        end else begin
            if (adv1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                    t1   <= in_tag;
`ifdef GF_SBOX_INV_EN
                    inv1 <= inv;
`endif
                end
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    s2_q <= s2_d;
                    t2   <= t1;
`ifdef GF_SBOX_INV_EN
                    inv2 <= inv1;
`endif
                end
            end
            if (adv3) begin
                v3 <= v2;
                if (v2) begin
                    s3_q <= s3_d;
                    t3   <= t2;
                end
            end
        end
    end

endmodule

// File: tb/tb_gf_sbox_pipe.sv
// Scoreboard bench for gf_sbox_pipe; reference S-box built from plain GF(2^8) arithmetic.
module tb_gf_sbox_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [1:0]  in_tag = '0;
    logic        inv_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [1:0]  out_tag;
    logic        busy;

    always #5 clk = ~clk;

    gf_sbox_pipe #(.LANES(4), .TAG_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
`ifdef GF_SBOX_INV_EN
        .inv       (inv_in),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [7:0]  sbox[256];
    logic [7:0]  isbox[256];
    int          checks = 0;
    int          failures = 0;
    logic        acc, emit, rdy;
    logic [31:0] od;
    logic [1:0]  ot;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0] x, iv, s;
        for (int v = 0; v < 256; v++) begin
            x  = 8'(v);
            iv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) iv = 8'(y);
            end
            s = iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]}
                   ^ {iv[3:0], iv[7:4]} ^ 8'h63;
            sbox[v]  = s;
            isbox[s] = x;
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] d, input logic use_inv);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8] = use_inv ? isbox[d[8*k +: 8]] : sbox[d[8*k +: 8]];
        end
        return r;
    endfunction

    // One clock of stimulus: drive at negedge, sample 1ns later, push on accept.
    task automatic cycle(input logic iv, input logic [31:0] d, input logic [1:0] t,
                         input logic ivx, input logic ordy);
        exp_t n;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        in_tag    = t;
        inv_in    = ivx;
        out_ready = ordy;
        #1;
        rdy  = in_ready;
        acc  = in_valid && in_ready;
        emit = out_valid && out_ready;
        od   = out_data;
        ot   = out_tag;
        if (acc) begin
            n.data = model(d, ivx);
            n.tag  = t;
            sb.push_back(n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_hold: got v=%b busy=%b data=%h want 0/0/0", out_valid, busy, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_ready: got %b want 1", in_ready);
        end
        cycle(1'b1, 32'hA5A55A5A, 2'd1, 1'b0, 1'b0);
        cycle(1'b1, 32'h01234567, 2'd3, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== model(32'hA5A55A5A, 1'b0) || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stall_before_reset: got v=%b data=%h busy=%b want 1/%h/1",
                     out_valid, out_data, busy, model(32'hA5A55A5A, 1'b0));
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 2'd0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset: got v=%b data=%h tag=%0d busy=%b want 0/0/0/0",
                     out_valid, out_data, out_tag, busy);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL after_reset: got ready=%b busy=%b want 1/0", in_ready, busy);
        end
        repeat (4) cycle(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL discard_inflight: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_known();
        logic [31:0] kin[2];
        logic [31:0] kout[2];
        logic [1:0]  ktag[2];
        int          lat;
        kin  = '{32'h00010253, 32'hFFFFFFFF};
        kout = '{32'h637C77ED, 32'h16161616};
        ktag = '{2'd2, 2'd1};
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, kin[i], ktag[i], 1'b0, 1'b1);
            lat = 0;
            for (int c = 1; c <= 10 && lat == 0; c++) begin
                cycle(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
                if (emit) begin
                    lat = c;
                    checks++;
                    if (od !== kout[i] || ot !== ktag[i]) begin
                        failures++;
                        $display("[TB] FAIL known_%0d: got %h tag %0d want %h tag %0d", i, od, ot, kout[i], ktag[i]);
                    end
                    void'(sb.pop_front());
                end
            end
            checks++;
            if (lat != 3) begin
                failures++;
                $display("[TB] FAIL latency_%0d: got %0d want 3", i, lat);
            end
        end
    endtask

    task automatic test_exhaustive();
        int sent = 0, n_emit = 0, first_emit = -1, last_emit = -1, last_acc = -1;
        for (int c = 0; c < 400 && (sent < 256 || sb.size() > 0); c++) begin
            cycle(sent < 256, {4{8'(sent)}}, 2'(sent), 1'b0, 1'b1);
            if (acc) begin
                sent++;
                last_acc = c;
            end
            if (emit) begin
                if (first_emit < 0) first_emit = c;
                last_emit = c;
                n_emit++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL exh_extra: got %h want no output", od);
                end else begin
                    e = sb.pop_front();
                    if (od !== e.data || ot !== e.tag) begin
                        failures++;
                        $display("[TB] FAIL exh_word%0d: got %h tag %0d want %h tag %0d", n_emit - 1, od, ot, e.data, e.tag);
                    end
                end
            end
        end
        checks++;
        if (n_emit != 256 || last_emit - first_emit != 255 || last_acc != 255 || sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL exh_rate: got emits=%0d span=%0d last_acc=%0d left=%0d want 256/255/255/0",
                     n_emit, last_emit - first_emit, last_acc, sb.size());
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w[8];
        logic [31:0] prev_od;
        logic [1:0]  prev_ot;
        logic        prev_stall = 1'b0, saw_low = 1'b0;
        int          sent = 0, n_emit = 0;
        for (int i = 0; i < 8; i++) w[i] = $urandom;
        prev_od = '0;
        prev_ot = '0;
        for (int c = 0; c < 60 && (sent < 8 || sb.size() > 0); c++) begin
            cycle(sent < 8, w[sent < 8 ? sent : 0], 2'(sent), 1'b0, !(c >= 4 && c < 9));
            if (!rdy) saw_low = 1'b1;
            if (acc) sent++;
            if (prev_stall) begin
                checks++;
                if (od !== prev_od || ot !== prev_ot) begin
                    failures++;
                    $display("[TB] FAIL bp_stable_c%0d: got %h/%0d want %h/%0d", c, od, ot, prev_od, prev_ot);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_od    = od;
            prev_ot    = ot;
            if (emit) begin
                n_emit++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL bp_extra: got %h want no output", od);
                end else begin
                    e = sb.pop_front();
                    if (od !== e.data || ot !== e.tag) begin
                        failures++;
                        $display("[TB] FAIL bp_word%0d: got %h tag %0d want %h tag %0d", n_emit - 1, od, ot, e.data, e.tag);
                    end
                end
            end
        end
        checks++;
        if (!saw_low || n_emit != 8 || sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL bp_summary: got ready_dropped=%b emits=%0d left=%0d want 1/8/0", saw_low, n_emit, sb.size());
        end
    endtask

    task automatic test_bubbles();
        logic ready_ok = 1'b1;
        int   sent = 0, n_emit = 0;
        for (int c = 0; c < 30 && (sent < 2 || sb.size() > 0); c++) begin
            cycle(sent < 2 && (c % 2 == 0), 32'hC0FFEE00 + 32'(c), 2'(c), 1'b0, c >= 2);
            if (!rdy) ready_ok = 1'b0;
            if (acc) sent++;
            if (emit) begin
                n_emit++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL bub_extra: got %h want no output", od);
                end else begin
                    e = sb.pop_front();
                    if (od !== e.data || ot !== e.tag) begin
                        failures++;
                        $display("[TB] FAIL bub_word%0d: got %h tag %0d want %h tag %0d", n_emit - 1, od, ot, e.data, e.tag);
                    end
                end
            end
        end
        checks++;
        if (!ready_ok || n_emit != 2 || sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL bub_summary: got ready_ok=%b emits=%0d left=%0d want 1/2/0", ready_ok, n_emit, sb.size());
        end
    endtask

`ifdef GF_SBOX_INV_EN
    task automatic test_inverse();
        logic [31:0] w[8];
        logic        wi[8];
        int          sent = 0, n_emit = 0;
        w[0] = 32'h637C77ED;
        wi[0] = 1'b1;
        w[1] = 32'h16161616;
        wi[1] = 1'b1;
        for (int i = 2; i < 8; i++) begin
            w[i]  = $urandom;
            wi[i] = 1'(i % 2);
        end
        for (int c = 0; c < 40 && (sent < 8 || sb.size() > 0); c++) begin
            cycle(sent < 8, w[sent < 8 ? sent : 0], 2'(sent), sent < 8 ? wi[sent] : 1'b0, 1'b1);
            if (acc) sent++;
            if (emit) begin
                checks++;
                if (n_emit == 0 && od !== 32'h00010253) begin
                    failures++;
                    $display("[TB] FAIL inv_known0: got %h want 00010253", od);
                end
                if (n_emit == 1 && od !== 32'hFFFFFFFF) begin
                    failures++;
                    $display("[TB] FAIL inv_known1: got %h want ffffffff", od);
                end
                if (sb.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL inv_extra: got %h want no output", od);
                end else begin
                    e = sb.pop_front();
                    if (od !== e.data || ot !== e.tag) begin
                        failures++;
                        $display("[TB] FAIL inv_word%0d: got %h tag %0d want %h tag %0d", n_emit, od, ot, e.data, e.tag);
                    end
                end
                n_emit++;
            end
        end
        checks++;
        if (n_emit != 8 || sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL inv_summary: got emits=%0d left=%0d want 8/0", n_emit, sb.size());
        end
    endtask
`endif

    initial begin
        build_tables();
        test_reset();
        test_known();
        test_exhaustive();
        test_backpressure();
        test_bubbles();
`ifdef GF_SBOX_INV_EN
        test_inverse();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish by 1ms want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
